// File: rtl/board_ram_arbiter.sv
// board_ram_arbiter: shares the single-port synchronous board RAM between the
// VGA renderer and the snake game logic. The renderer owns the RAM while
// video_on=1. Game requests are queued in a small FIFO and drained one per
// cycle only while video_on=0, so game updates never disturb a visible frame.
//
// Ports:
//   clock_25, reset          25 MHz clock, asynchronous active-low reset
//   video_on                 1 = active video, renderer owns the RAM
//   vga_rd_addr/vga_rd_data  renderer address in, read data out (1-cycle latency)
//   game_req_*               game request channel (valid/ready, we, addr, wdata)
//   game_rd_valid/_data      one-cycle read response pulse and data
//   fifo_count               number of queued game requests
//   blank_drained            one-cycle pulse when the queue empties in blanking
//   ram_addr/ram_we/ram_wdata/ram_rdata  board RAM port
module board_ram_arbiter #(
    parameter int unsigned ADDR_W     = 11,
    parameter int unsigned DATA_W     = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                         clock_25,
    input  logic                         reset,
    input  logic                         video_on,
    input  logic [ADDR_W-1:0]            vga_rd_addr,
    output logic [DATA_W-1:0]            vga_rd_data,
    input  logic                         game_req_valid,
    input  logic                         game_req_we,
    input  logic [ADDR_W-1:0]            game_req_addr,
    input  logic [DATA_W-1:0]            game_req_wdata,
    output logic                         game_req_ready,
    output logic                         game_rd_valid,
    output logic [DATA_W-1:0]            game_rd_data,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         blank_drained,
    output logic [ADDR_W-1:0]            ram_addr,
    output logic                         ram_we,
    output logic [DATA_W-1:0]            ram_wdata,
    input  logic [DATA_W-1:0]            ram_rdata
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } entry_t;

    typedef enum logic [1:0] {
        VGA_PHASE   = 2'd0,
        BLANK_SERVE = 2'd1,
        BLANK_IDLE  = 2'd2
    } state_t;

    entry_t             r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_next;
    state_t             r_state;
    state_t             w_state_next;
    logic               r_rd_valid;
    logic               r_blank_drained;
    logic               w_drain_done;
    logic               w_push;
    logic               w_pop;
    entry_t             w_head;

    // Queue handshake; the head is only eligible from the cycle after its push
    assign game_req_ready = (r_count != CNT_W'(FIFO_DEPTH));
    assign w_push         = game_req_valid & game_req_ready;
    assign w_pop          = ~video_on & (r_count != '0);
    assign w_head         = r_mem[r_rd_ptr];

    assign fifo_count     = r_count;
    assign game_rd_valid  = r_rd_valid;
    assign blank_drained  = r_blank_drained;
    assign vga_rd_data    = ram_rdata;
    assign game_rd_data   = ram_rdata;

    // Queue occupancy after this cycle's push/pop
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Queue storage (no reset needed: contents are qualified by r_count)
    always_ff @(posedge clock_25) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{we: game_req_we, addr: game_req_addr, wdata: game_req_wdata};
        end
    end

    // Queue pointers and count; pointers wrap naturally at a power-of-two depth
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= w_count_next;
        end
    end

    // RAM port mux; a pop can only happen with video_on=0
    always_comb begin
        ram_addr  = vga_rd_addr;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (w_pop) begin
            ram_addr  = w_head.addr;
            ram_we    = w_head.we;
            ram_wdata = w_head.wdata;
        end
    end

    // Phase tracking, used to flag the end of a complete blanking drain
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) r_state <= VGA_PHASE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_drain_done = 1'b0;
        case (r_state)
            VGA_PHASE: begin
                if (!video_on) w_state_next = (r_count != '0) ? BLANK_SERVE : BLANK_IDLE;
            end
            BLANK_SERVE: begin
                if (video_on) begin
                    w_state_next = VGA_PHASE;
                end else if (w_count_next == '0) begin
                    w_state_next = BLANK_IDLE;
                    w_drain_done = 1'b1;
                end
            end
            BLANK_IDLE: begin
                // A non-empty queue here (push that raced the phase change) is served too
                if (video_on)                       w_state_next = VGA_PHASE;
                else if (w_push || r_count != '0)   w_state_next = BLANK_SERVE;
            end
            default: w_state_next = VGA_PHASE;
        endcase
    end

    // Registered read-response and drain pulses
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            r_rd_valid      <= 1'b0;
            r_blank_drained <= 1'b0;
        end else begin
            r_rd_valid      <= w_pop & ~w_head.we;
            r_blank_drained <= w_drain_done;
        end
    end

endmodule

// File: doc/board_ram_arbiter.md
Name: board_ram_arbiter

Overview:
Shares the single-port synchronous board RAM (one cell code per grid square) between the VGA renderer and the snake game logic. The VGA renderer owns the RAM whenever video_on=1. Game reads and writes are queued in a small FIFO and drained only while video_on=0, so game updates triggered by game_tik never corrupt the visible frame. Sits between snake_game_fsm/VGA pixel generator and the board RAM instance.

Parameters:
ADDR_W, 11, board RAM address width (40x30 = 1200 cells)
DATA_W, 2, cell code width (empty/body/head/food)
FIFO_DEPTH, 4, game request queue depth (power of two, >=2)

Ports:
clock_25  input  1  25 MHz system clock
reset  input  1  asynchronous, active-low reset
video_on  input  1  1 = VGA active region, renderer owns RAM
vga_rd_addr  input  ADDR_W  renderer cell address
vga_rd_data  output  DATA_W  renderer read data, = ram_rdata
game_req_valid  input  1  game request present
game_req_we  input  1  1 = write, 0 = read
game_req_addr  input  ADDR_W  game cell address
game_req_wdata  input  DATA_W  game write data
game_req_ready  output  1  request accepted when valid & ready
game_rd_valid  output  1  one-cycle pulse, game read data valid
game_rd_data  output  DATA_W  game read data, = ram_rdata
fifo_count  output  clog2(FIFO_DEPTH)+1  queued requests
blank_drained  output  1  one-cycle pulse: queue emptied during blanking
ram_addr  output  ADDR_W  RAM address
ram_we  output  1  RAM write enable
ram_wdata  output  DATA_W  RAM write data
ram_rdata  input  DATA_W  RAM read data, 1-cycle latency

Behaviour:
- Reset: asynchronous, active-low, clock clock_25. FIFO emptied (fifo_count=0), state=VGA_PHASE, game_rd_valid=0, blank_drained=0, ram_we=0. game_req_ready=1 once reset is released. Reset in mid-drain discards queued requests and any pending read response.
- FIFO: game_req_valid & game_req_ready pushes {we, addr, wdata}. game_req_ready = (fifo_count != FIFO_DEPTH). There is no bypass. An entry pushed in cycle N can be popped in cycle N+1 at the earliest. Simultaneous push and pop is allowed, and fifo_count is unchanged in that case. Pointers wrap modulo FIFO_DEPTH.
- Pop condition: video_on=0 & fifo_count!=0. At most one pop per cycle, in strict FIFO order.
- RAM mux (combinational):
  - video_on=1: ram_addr=vga_rd_addr, ram_we=0.
  - Pop cycle: ram_addr=head.addr, ram_we=head.we, ram_wdata=head.wdata.
  - Otherwise: ram_addr=vga_rd_addr, ram_we=0.
  - ram_we is never 1 while video_on=1.
- Read response: a popped read in cycle N gives game_rd_valid=1 in cycle N+1 (registered flag), with game_rd_data=ram_rdata. The pulse still fires if video_on rises in cycle N+1. Writes produce no response.
- vga_rd_data = ram_rdata always. Renderer latency is 1 cycle. Data is meaningful only in cycles following video_on=1 address cycles.
- FSM (registered state, next-state from video_on and fifo_count):
  - VGA_PHASE: video_on=1, no pops. video_on=0 & count!=0 -> BLANK_SERVE. video_on=0 & count==0 -> BLANK_IDLE.
  - BLANK_SERVE: pop each cycle. video_on=1 -> VGA_PHASE (remaining entries stay queued). Count reaches 0 after a pop with no push -> BLANK_IDLE.
  - BLANK_IDLE: video_on=1 -> VGA_PHASE. A push -> BLANK_SERVE.
- blank_drained: one-cycle pulse on the BLANK_SERVE -> BLANK_IDLE transition cycle, registered. At most one pulse per drain. No pulse if video_on rises before the queue empties.
- Widths: fifo_count saturates logically at FIFO_DEPTH; overflow is impossible because ready blocks the push. Out-of-range addresses (>=1200) are passed through unchecked.

Test Plan:
- Reset with video_on=0, no requests -> ready=1, fifo_count=0, ram_we=0, no game_rd_valid or blank_drained pulses.
- video_on=1, push 4 writes (addr 5..8, data 2'b01) -> fifo_count=4, ready=0, 5th request stalls, ram_we stays 0. Then video_on=0 -> four consecutive ram_we=1 cycles at addr 5,6,7,8. blank_drained pulses once, fifo_count=0.
- video_on=0, read of addr 10 whose RAM holds 2'b11 -> game_rd_valid=1 exactly 1 cycle after the pop cycle, game_rd_data=2'b11.
- Push 3 writes, video_on=0 for 1 cycle then 1 -> exactly one write issued, fifo_count=2, no blank_drained. The next blanking issues the remaining two in order.
- Simultaneous push and pop at fifo_count=2 during blanking -> fifo_count stays 2, ordering preserved.
- Assert reset with 3 queued entries mid-drain -> fifo_count=0 immediately, ram_we=0, no pending game_rd_valid after release.
